rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 114 +++++++++++
 tb/tb_rr_arbiter8.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// All outputs are registered; the pointer only advances when a grant is released.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic [2:0] release_ptr;
    logic [3:0] hit_cur;
    logic [3:0] hit_rel;

    // Returns {found, index}; scanning from the far end lets the nearest hit win.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign release_ptr = gnt_idx_q + 3'd1;
    assign hit_cur     = rr_search(req, ptr_q);
    assign hit_rel     = rr_search(req, release_ptr);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_cur[3]) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = hit_cur[2:0];
                    gnt_d       = 8'b1 << hit_cur[2:0];
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                end
            end
            ST_GRANT: begin
                if (req[gnt_idx_q] && (hold_cnt_q < MAX_HOLD_C)) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    // Release: the search restarts just past the old holder, so it is seen last.
                    ptr_d = release_ptr;
                    if (hit_rel[3]) begin
                        gnt_idx_d   = hit_rel[2:0];
                        gnt_d       = 8'b1 << hit_rel[2:0];
                        gnt_valid_d = 1'b1;
                        hold_cnt_d  = 8'd1;
                    end else begin
                        state_d     = ST_IDLE;
                        gnt_idx_d   = 3'd0;
                        gnt_d       = 8'd0;
                        gnt_valid_d = 1'b0;
                        hold_cnt_d  = 8'd0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_idx_d   = 3'd0;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: four instances (MAX_HOLD 8, 1, 4, 2) share clock, reset and req.
// Vectors from a table plus hand-written reset and hold-counter sequences.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt_a [4];
    logic [2:0] idx_a [4];
    logic       val_a [4];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         sel;
        bit         rst;
        logic [7:0] req;
        logic       v;
        logic [2:0] idx;
        string      name;
    } vec_t;

    typedef struct {
        int          sel;
        logic [11:0] exp;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    rr_arbiter8 #(.MAX_HOLD(8)) dut_m8 (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a[0]), .gnt_idx(idx_a[0]), .gnt_valid(val_a[0]));
    rr_arbiter8 #(.MAX_HOLD(1)) dut_m1 (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a[1]), .gnt_idx(idx_a[1]), .gnt_valid(val_a[1]));
    rr_arbiter8 #(.MAX_HOLD(4)) dut_m4 (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a[2]), .gnt_idx(idx_a[2]), .gnt_valid(val_a[2]));
    rr_arbiter8 #(.MAX_HOLD(2)) dut_m2 (.clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a[3]), .gnt_idx(idx_a[3]), .gnt_valid(val_a[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] outs(input int sel);
        return {val_a[sel], idx_a[sel], gnt_a[sel]};
    endfunction

    function automatic logic [11:0] expect_word(input logic v, input logic [2:0] idx);
        logic [7:0] g;
        g = v ? (8'b1 << idx) : 8'h00;
        return {v, idx, g};
    endfunction

    task automatic drive_check(input int sel, input logic [7:0] r, input logic v,
                               input logic [2:0] idx, input string name);
        exp_t e;
        @(negedge clk);
        req    = r;
        e.sel  = sel;
        e.exp  = expect_word(v, idx);
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.name, outs(e.sel), e.exp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'hFF;
        #1;
        for (int s = 0; s < 4; s++) check("reset_async", outs(s), 12'h000);
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) check("reset_held", outs(s), 12'h000);
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic add(input int sel, input bit rst, input logic [7:0] r, input logic v,
                       input logic [2:0] idx, input string name);
        vec_t t;
        t.sel = sel; t.rst = rst; t.req = r; t.v = v; t.idx = idx; t.name = name;
        vecs.push_back(t);
    endtask

    initial begin
        logic [7:0] onehot;
        rst_n = 1'b1;
        req   = 8'h00;

        // Single requesters in turn, MAX_HOLD=8
        add(0, 1, 8'h00, 0, 3'd0, "idle_stays");
        for (int i = 0; i < 8; i++) begin
            onehot = 8'b1 << i;
            add(0, 0, onehot, 1, 3'(i), "single_req");
            add(0, 0, onehot, 1, 3'(i), "single_req_hold");
        end
        add(0, 0, 8'h00, 0, 3'd0, "single_idle");
        // Fairness with MAX_HOLD=1
        for (int i = 0; i < 10; i++) add(1, i == 0, 8'hFF, 1, 3'(i % 8), "rr_fair");
        // Max hold with MAX_HOLD=4
        for (int i = 0; i < 10; i++) add(2, i == 0, 8'h09, 1, (i >= 4 && i < 8) ? 3'd3 : 3'd0, "max_hold4");
        // Max hold with default MAX_HOLD=8
        for (int i = 0; i < 9; i++) add(0, i == 0, 8'h03, 1, (i == 8) ? 3'd1 : 3'd0, "max_hold8");
        // Other requests rising during a hold do not move the grant
        add(2, 1, 8'h01, 1, 3'd0, "no_preempt");
        add(2, 0, 8'h03, 1, 3'd0, "no_preempt");
        add(2, 0, 8'h07, 1, 3'd0, "no_preempt");
        add(2, 0, 8'h0F, 1, 3'd0, "no_preempt");
        add(2, 0, 8'h0F, 1, 3'd1, "no_preempt_rel");
        // MAX_HOLD=1 sole requester re-granted each cycle, then idle
        add(1, 1, 8'h01, 1, 3'd0, "m1_sole");
        add(1, 0, 8'h01, 1, 3'd0, "m1_sole");
        add(1, 0, 8'h01, 1, 3'd0, "m1_sole");
        add(1, 0, 8'h00, 0, 3'd0, "m1_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) apply_reset();
            drive_check(vecs[i].sel, vecs[i].req, vecs[i].v, vecs[i].idx, vecs[i].name);
        end

        // Early release of requester 7 wraps the pointer; new requests join the same search
        apply_reset();
        drive_check(0, 8'h80, 1, 3'd7, "wrap_g7");
        drive_check(0, 8'h80, 1, 3'd7, "wrap_g7");
        drive_check(0, 8'h42, 1, 3'd1, "wrap_g1");
        check("wrap_ptr", {9'd0, dut_m8.ptr_q}, 12'h000);
        drive_check(0, 8'h42, 1, 3'd1, "wrap_g1_hold");

        // Sole holder re-grant with MAX_HOLD=2
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_check(3, 8'h20, 1, 3'd5, "sole_regrant");
            check("sole_hold_cnt", {4'd0, dut_m2.hold_cnt_q}, (i % 2 == 0) ? 12'd1 : 12'd2);
        end

        // Reset pulsed mid-grant after the pointer has moved
        apply_reset();
        drive_check(0, 8'h01, 1, 3'd0, "mid_rst_g0");
        drive_check(0, 8'h04, 1, 3'd2, "mid_rst_g2");
        check("mid_rst_ptr_before", {9'd0, dut_m8.ptr_q}, 12'h001);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_async", outs(0), 12'h000);
        check("mid_rst_ptr", {9'd0, dut_m8.ptr_q}, 12'h000);
        check("mid_rst_hold", {4'd0, dut_m8.hold_cnt_q}, 12'h000);
        @(posedge clk);
        #1;
        check("mid_rst_held", outs(0), 12'h000);
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;
        drive_check(0, 8'h00, 0, 3'd0, "post_rst_idle");
        drive_check(0, 8'h84, 1, 3'd2, "post_rst_g2");

        if (sb_q.size() != 0) check("scoreboard_empty", 12'(sb_q.size()), 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
